// File: rtl/regfile_writeback_pkg.sv
// Shared types and constants for the register-file writeback front end.
// Holds address/data widths, the zero-register id and the queue entry struct.
package regfile_writeback_pkg;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;

   localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] address;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_wb_queue.sv
// Killable in-order FIFO for long-latency results.
// Ports: clock/reset, push/push_entry, pop, kill_en/kill_address,
//   full/empty/count, head entry, raw entry array plus read pointer.
module wb_queue
   import regfile_writeback_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PW    = $clog2(DEPTH),
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              push,
   input  wb_entry_t         push_entry,
   input  logic              pop,
   input  logic              kill_en,
   input  logic [ADDR_W-1:0] kill_address,
   output logic              full,
   output logic              empty,
   output logic [CW-1:0]     count,
   output wb_entry_t         head,
   output wb_entry_t         entries [DEPTH],
   output logic [PW-1:0]     rd_ptr
);

   wb_entry_t     mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic          push_kill;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

   // A same-cycle pipeline write to the pushed address makes it stale.
   assign push_kill = kill_en &&
                      (push_entry.address == kill_address);

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         entries[i] = mem[i];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (kill_en) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (mem[i].address == kill_address) begin
                  mem[i].valid <= 1'b0;
               end
            end
         end
         // Popped slots are invalidated so the forwarding
         // search can ignore occupancy.
         if (pop) begin
            mem[rd_ptr].valid <= 1'b0;
            rd_ptr            <= rd_ptr + 1'b1;
         end
         if (push) begin
            mem[wr_ptr].valid   <= push_entry.valid & ~push_kill;
            mem[wr_ptr].address <= push_entry.address;
            mem[wr_ptr].data    <= push_entry.data;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/regfile_writeback.sv
// Writer-side front end owning the register-file write port.
// Ports: clock/reset, pipe_* single-cycle results, lu_* long-latency
//   handshake, write_* registered write stream, fwd_* two bypass lookups.
module regfile_writeback
   import regfile_writeback_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              pipe_valid,
   input  logic [ADDR_W-1:0] pipe_address,
   input  logic [DATA_W-1:0] pipe_data,
   input  logic              lu_valid,
   output logic              lu_ready,
   input  logic [ADDR_W-1:0] lu_address,
   input  logic [DATA_W-1:0] lu_data,
   output logic              write_enable,
   output logic [ADDR_W-1:0] write_address,
   output logic [DATA_W-1:0] write_data,
   input  logic [ADDR_W-1:0] fwd_address_a,
   output logic              fwd_hit_a,
   output logic [DATA_W-1:0] fwd_data_a,
   input  logic [ADDR_W-1:0] fwd_address_b,
   output logic              fwd_hit_b,
   output logic [DATA_W-1:0] fwd_data_b
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic          pipe_write;
   logic          q_push;
   logic          q_pop;
   logic          q_full;
   logic          q_empty;
   logic [CW-1:0] q_count;
   wb_entry_t     q_head;
   wb_entry_t     q_entries [DEPTH];
   logic [PW-1:0] q_rd_ptr;
   wb_entry_t     push_entry;

   assign pipe_write = pipe_valid && (pipe_address != ZERO_REG);

   // Ready depends only on registered occupancy: no pass-through.
   assign lu_ready = ~reset && (q_count < CW'(DEPTH));

   // Address-0 results finish the handshake but are dropped.
   assign q_push = lu_valid && ~q_full && ~reset &&
                   (lu_address != ZERO_REG);
   assign q_pop  = ~pipe_write && ~q_empty;

   assign push_entry = '{valid: 1'b1,
                         address: lu_address,
                         data: lu_data};

   wb_queue #(
      .DEPTH(DEPTH)
   ) u_queue (
      .clock        (clock),
      .reset        (reset),
      .push         (q_push),
      .push_entry   (push_entry),
      .pop          (q_pop),
      .kill_en      (pipe_write),
      .kill_address (pipe_address),
      .full         (q_full),
      .empty        (q_empty),
      .count        (q_count),
      .head         (q_head),
      .entries      (q_entries),
      .rd_ptr       (q_rd_ptr)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         write_enable  <= 1'b0;
         write_address <= '0;
         write_data    <= '0;
      end else if (pipe_write) begin
         write_enable  <= 1'b1;
         write_address <= pipe_address;
         write_data    <= pipe_data;
      end else if (~q_empty) begin
         // A killed head still pops, but issues no write.
         write_enable <= q_head.valid;
         if (q_head.valid) begin
            write_address <= q_head.address;
            write_data    <= q_head.data;
         end
      end else begin
         write_enable <= 1'b0;
      end
   end

   // Returns {hit, data}. The output stage is the oldest candidate;
   // queue slots are walked oldest to newest so the newest match wins.
   function automatic logic [DATA_W:0] lookup(
      input logic [ADDR_W-1:0] addr,
      input wb_entry_t         ents [DEPTH],
      input logic [PW-1:0]     rd,
      input logic              we,
      input logic [ADDR_W-1:0] wa,
      input logic [DATA_W-1:0] wd
   );
      logic [DATA_W:0] r;
      logic [PW-1:0]   idx;
      r = '0;
      if (addr != ZERO_REG) begin
         if (we && (wa == addr)) begin
            r = {1'b1, wd};
         end
         for (int k = 0; k < DEPTH; k++) begin
            idx = rd + PW'(k);
            if (ents[idx].valid && (ents[idx].address == addr)) begin
               r = {1'b1, ents[idx].data};
            end
         end
      end
      return r;
   endfunction

   always_comb begin
      {fwd_hit_a, fwd_data_a} = lookup(fwd_address_a, q_entries,
                                       q_rd_ptr, write_enable,
                                       write_address, write_data);
      {fwd_hit_b, fwd_data_b} = lookup(fwd_address_b, q_entries,
                                       q_rd_ptr, write_enable,
                                       write_address, write_data);
   end

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Writer-side front end for the 32x32 register file. It owns the single register-file write port.
- Merges single-cycle pipeline results with results from long-latency units (mul/div/HI-LO move, cache-miss load) into one registered write stream.
- Long-latency results are buffered in a small killable queue.
- Provides two bypass lookups so decode sees values that are pending or still being written.

Parameters:
- DEPTH, 4, long-latency result queue entries (power of two, >=2)
- ADDR_W, 5, register address width
- DATA_W, 32, register data width

Ports:
- clock  in  1  system clock; all state updates on posedge
- reset  in  1  synchronous, active-high; one clock; reset sampled on posedge clock
- pipe_valid  in  1  pipeline WB result present this cycle (never stalled)
- pipe_address  in  ADDR_W  destination register of pipeline result
- pipe_data  in  DATA_W  pipeline result value
- lu_valid  in  1  long-latency result offered
- lu_ready  out  1  queue can accept; transfer when lu_valid & lu_ready at posedge
- lu_address  in  ADDR_W  destination of long-latency result
- lu_data  in  DATA_W  long-latency result value
- write_enable  out  1  registered register-file write strobe (file commits on negedge)
- write_address  out  ADDR_W  registered write address
- write_data  out  DATA_W  registered write data
- fwd_address_a  in  ADDR_W  bypass lookup A (decode operand rs)
- fwd_hit_a  out  1  pending/in-flight value exists for A
- fwd_data_a  out  DATA_W  newest value for A, 0 when no hit
- fwd_address_b  in  ADDR_W  bypass lookup B (decode operand rt)
- fwd_hit_b  out  1  as A
- fwd_data_b  out  DATA_W  as A

Behaviour:
- Reset: write_enable=0, write_address=0, write_data=0, queue emptied (count=0, all entry valid bits 0), lu_ready=0 while reset high.
- Address 0 is never written:
  - pipe_address==0 is treated as no pipeline write.
  - An accepted lu with address 0 completes its handshake but is not enqueued.
- Output stage, loaded each posedge with exactly one of the following, in priority order:
  1. Pipeline result, if pipe_valid and pipe_address!=0. Latency: valid at posedge N, write_enable high during cycle N+1.
  2. Otherwise, the queue head, if the queue is non-empty. The head is popped. If the head's valid bit is clear (killed), write_enable=0 that cycle.
  3. Otherwise, write_enable=0. Address and data hold their previous values.
- Queue:
  - In-order FIFO with wrapping read and write pointers and a count.
  - Each entry holds {valid, address, data}.
  - lu_ready = (count < DEPTH), computed from registered count only. There is no same-cycle pass-through: full plus a simultaneous pop keeps lu_ready=0 that cycle.
  - Simultaneous push and pop leaves count unchanged.
  - Earliest write of an lu result accepted at posedge N is cycle N+2.
- Kill rule (pipeline result is architecturally younger):
  - A pipeline write to R at posedge clears the valid bit of every queued entry with address R.
  - An lu entry for R accepted in the same cycle is enqueued with valid=0.
- Forwarding, combinational, computed per port:
  - Lookup address 0: no hit, data 0.
  - Otherwise search the valid queue entries newest to oldest, then the output stage (write_enable & write_address match).
  - The first match gives hit=1 and its data. No match gives hit=0 and data=0.
- Reset mid-operation: queued and in-flight entries are discarded and no write is issued in the cycle after reset.

Decomposition:
- Shared package: ADDR_W, DATA_W, ZERO_REG (5'd0), and the queue entry struct {valid, address, data}.
- One sub-module: wb_queue. Killable FIFO with push, pop, kill_address/kill_en, full/empty/count, head, and an entry-array view for the forwarding search.
- Arbitration, output register and forwarding logic stay in regfile_writeback.

Test Plan:
- Basic pipe: pipe_valid=1, addr=3, data=0xDEADBEEF at posedge 1 -> cycle 2 write_enable=1, write_address=3, write_data=0xDEADBEEF; cycle 3 write_enable=0.
- Drain order: push lu (5,0x11) then (6,0x22) with no pipe traffic -> writes (5,0x11) in cycle N+2 and (6,0x22) in cycle N+3; lu_ready stays 1.
- Priority and kill: queue holds (7,0xAA); pipe (7,0xBB) in the same cycle as a pipe stall of the queue -> write (7,0xBB); the queued entry pops later with write_enable=0; fwd_address_a=7 returns 0xBB, never 0xAA.
- Full: with continuous pipe traffic, 4 lu pushes -> lu_ready=0; a 5th offer is held; after one idle pipe cycle the queue pops and lu_ready returns to 1 the next cycle.
- Zero register: pipe addr=0 with a non-empty queue -> the queue drains that cycle; lu addr=0 is accepted and never written; fwd_address=0 gives hit=0, data=0.
- Reset mid-flight: 3 entries queued, reset for 1 cycle -> write_enable=0 and lu_ready=0 in the reset cycle, no write afterwards, fwd_hit=0 for all addresses.
